// File: rtl/alarm_siren_ctrl_pkg.sv
// Shared encodings for the siren controller: upstream alarm FSM states,
// siren state enum and a counter-width helper.
package alarm_pkg;

  // Upstream alarm FSM state encodings
  localparam logic [1:0] FSM_OFF       = 2'b00;
  localparam logic [1:0] FSM_ARMED     = 2'b01;
  localparam logic [1:0] FSM_TRIGGERED = 2'b10;
  localparam logic [1:0] FSM_ALARM_ON  = 2'b11;

  typedef enum logic [1:0] {
    SIREN_IDLE    = 2'd0,
    SIREN_SOUND   = 2'd1,
    SIREN_HOLDOFF = 2'd2,
    SIREN_MUTED   = 2'd3
  } siren_state_e;

  // Width of a counter that runs 0..p-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/alarm_siren_ctrl_if.sv
// Request/indicator bundle between the alarm FSM side and the siren controller.
interface alarm_siren_ctrl_if;
  logic       alarm;
  logic [1:0] state;
  logic       silence;
  logic       siren;
  logic       strobe;
  logic       active;
  logic       muted;
  logic [1:0] resound_cnt;

  modport master (
    output alarm, state, silence,
    input  siren, strobe, active, muted, resound_cnt
  );

  modport slave (
    input  alarm, state, silence,
    output siren, strobe, active, muted, resound_cnt
  );
endinterface

// File: rtl/alarm_siren_ctrl_siren_tone_gen.sv
// Two-tone warbling square-wave generator. clr restarts on the HI tone with
// siren equal to en; a divisor change only takes effect at a tone wrap.
module siren_tone_gen
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_HI_DIV = 4,
  parameter int unsigned TONE_LO_DIV = 6,
  parameter int unsigned WARBLE_LEN  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic siren
);

  localparam int unsigned TONE_MAX = (TONE_HI_DIV > TONE_LO_DIV) ? TONE_HI_DIV : TONE_LO_DIV;
  localparam int unsigned TW       = cnt_width(TONE_MAX);
  localparam int unsigned WW       = cnt_width(WARBLE_LEN);

  logic [TW-1:0] tone_cnt;
  logic [WW-1:0] warble_cnt;
  logic          sel_hi;
  logic          cur_hi;
  logic [TW-1:0] half_m1;
  logic          tone_wrap;
  logic          warble_wrap;
  logic          sel_nxt;

  // Wrap detection and the tone select that a wrap in this cycle would adopt
  always_comb begin
    half_m1     = cur_hi ? TW'(TONE_HI_DIV - 1) : TW'(TONE_LO_DIV - 1);
    tone_wrap   = (tone_cnt == half_m1);
    warble_wrap = (warble_cnt == WW'(WARBLE_LEN - 1));
    sel_nxt     = warble_wrap ? ~sel_hi : sel_hi;
  end

  // Tone counter, warble counter and siren flop
  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt   <= '0;
      warble_cnt <= '0;
      sel_hi     <= 1'b1;
      cur_hi     <= 1'b1;
      siren      <= 1'b0;
    end else if (clr) begin
      tone_cnt   <= '0;
      warble_cnt <= '0;
      sel_hi     <= 1'b1;
      cur_hi     <= 1'b1;
      siren      <= en;
    end else if (en) begin
      tone_cnt   <= tone_wrap ? '0 : tone_cnt + 1'b1;
      warble_cnt <= warble_wrap ? '0 : warble_cnt + 1'b1;
      sel_hi     <= sel_nxt;
      if (tone_wrap) begin
        siren  <= ~siren;
        cur_hi <= sel_nxt;
      end
    end
  end

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Siren/strobe sequencer: sounds on alarm_on, auto-silences on timeout or
// acknowledge, re-sounds after a lockout a bounded number of times, then mutes.
module alarm_siren_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned TONE_HI_DIV = 4,
  parameter int unsigned TONE_LO_DIV = 6,
  parameter int unsigned WARBLE_LEN  = 32,
  parameter int unsigned STROBE_DIV  = 16,
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned LOCKOUT     = 64,
  parameter int unsigned MAX_RESOUND = 3
) (
  input  logic               clk,
  input  logic               rst,
  alarm_siren_ctrl_if.slave  bus
);

  localparam int unsigned TOW = cnt_width(TIMEOUT);
  localparam int unsigned LKW = cnt_width(LOCKOUT);
  localparam int unsigned STW = cnt_width(STROBE_DIV);

  siren_state_e   st_q, st_d;
  logic [TOW-1:0] to_q, to_d;
  logic [LKW-1:0] lk_q, lk_d;
  logic [STW-1:0] sb_q, sb_d;
  logic           strobe_q, strobe_d;
  logic [1:0]     rs_q, rs_d;
  logic           active_q, active_d;
  logic           muted_q, muted_d;
  logic           trigger_c;
  logic           tone_en_c;
  logic           tone_clr_c;

  // Next state, counters and registered-output next values
  always_comb begin
    st_d       = st_q;
    to_d       = '0;
    lk_d       = '0;
    sb_d       = '0;
    strobe_d   = 1'b0;
    rs_d       = rs_q;
    trigger_c  = bus.alarm && (bus.state == FSM_ALARM_ON);

    case (st_q)
      SIREN_IDLE: begin
        if (trigger_c) st_d = SIREN_SOUND;
      end
      SIREN_SOUND: begin
        if (!trigger_c)                      st_d = SIREN_IDLE;
        else if (bus.silence)                st_d = SIREN_HOLDOFF;
        else if (to_q == TOW'(TIMEOUT - 1))  st_d = SIREN_HOLDOFF;
      end
      SIREN_HOLDOFF: begin
        if (!trigger_c) begin
          st_d = SIREN_IDLE;
        end else if (lk_q == LKW'(LOCKOUT - 1)) begin
          if (32'(rs_q) < MAX_RESOUND) begin
            st_d = SIREN_SOUND;
            rs_d = rs_q + 2'd1;
          end else begin
            st_d = SIREN_MUTED;
          end
        end
      end
      SIREN_MUTED: begin
        if (!trigger_c) st_d = SIREN_IDLE;
      end
      default: st_d = SIREN_IDLE;
    endcase

    if (st_d == SIREN_IDLE) rs_d = 2'd0;

    // Timeout and lockout counters restart on each entry to their state
    if (st_d == SIREN_SOUND && st_q == SIREN_SOUND)     to_d = to_q + 1'b1;
    if (st_d == SIREN_HOLDOFF && st_q == SIREN_HOLDOFF) lk_d = lk_q + 1'b1;

    // Strobe runs continuously outside IDLE, starting from 0 on the entry edge
    if (st_d != SIREN_IDLE && st_q != SIREN_IDLE) begin
      if (sb_q == STW'(STROBE_DIV - 1)) begin
        sb_d     = '0;
        strobe_d = ~strobe_q;
      end else begin
        sb_d     = sb_q + 1'b1;
        strobe_d = strobe_q;
      end
    end

    active_d   = (st_d == SIREN_SOUND);
    muted_d    = (st_d == SIREN_MUTED);
    tone_en_c  = (st_d == SIREN_SOUND);
    tone_clr_c = (st_d != SIREN_SOUND) || (st_q != SIREN_SOUND);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= SIREN_IDLE;
      to_q     <= '0;
      lk_q     <= '0;
      sb_q     <= '0;
      strobe_q <= 1'b0;
      rs_q     <= 2'd0;
      active_q <= 1'b0;
      muted_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      to_q     <= to_d;
      lk_q     <= lk_d;
      sb_q     <= sb_d;
      strobe_q <= strobe_d;
      rs_q     <= rs_d;
      active_q <= active_d;
      muted_q  <= muted_d;
    end
  end

  siren_tone_gen #(
    .TONE_HI_DIV (TONE_HI_DIV),
    .TONE_LO_DIV (TONE_LO_DIV),
    .WARBLE_LEN  (WARBLE_LEN)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .en    (tone_en_c),
    .clr   (tone_clr_c),
    .siren (bus.siren)
  );

  assign bus.strobe      = strobe_q;
  assign bus.active      = active_q;
  assign bus.muted       = muted_q;
  assign bus.resound_cnt = rs_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Directed bench for alarm_siren_ctrl with default parameters.
module tb_alarm_siren_ctrl;

  logic   clk = 1'b0;
  logic   rst;
  integer checks = 0;
  integer errors = 0;

  alarm_siren_ctrl_if bus ();

  alarm_siren_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.alarm   = 1'b0;
    bus.state   = 2'b00;
    bus.silence = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.alarm   = 1'b1;
    bus.state   = 2'b11;
    bus.silence = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.siren, bus.strobe, bus.active, bus.muted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000", {bus.siren, bus.strobe, bus.active, bus.muted});
    end
    checks++;
    if (bus.resound_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_resound got %0d exp 0", bus.resound_cnt);
    end
    // first sample after release enters SOUND
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.siren, bus.active} !== 2'b11) begin
      errors++;
      $display("FAIL reset_first_trigger got %b exp 11", {bus.siren, bus.active});
    end
  endtask

  task automatic test_tone();
    int t;
    logic exp_siren, exp_strobe;
    do_reset();
    bus.alarm = 1'b1;
    bus.state = 2'b11;
    tick();
    checks++;
    if ({bus.siren, bus.active, bus.strobe} !== 3'b110) begin
      errors++;
      $display("FAIL tone_entry got %b exp 110", {bus.siren, bus.active, bus.strobe});
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      t = (k <= 32) ? (k / 4) : (8 + (k - 32) / 6);
      exp_siren  = (t % 2) == 0;
      exp_strobe = ((k / 16) % 2) == 1;
      checks++;
      if (bus.siren !== exp_siren) begin
        errors++;
        $display("FAIL tone_siren k=%0d got %b exp %b", k, bus.siren, exp_siren);
      end
      checks++;
      if ({bus.strobe, bus.active} !== {exp_strobe, 1'b1}) begin
        errors++;
        $display("FAIL tone_strobe k=%0d got %b exp %b", k, {bus.strobe, bus.active}, {exp_strobe, 1'b1});
      end
    end
  endtask

  task automatic test_timeout_resound();
    do_reset();
    bus.alarm = 1'b1;
    bus.state = 2'b11;
    tick();
    for (int r = 0; r < 4; r++) begin
      repeat (199) tick();
      checks++;
      if (bus.active !== 1'b1) begin
        errors++;
        $display("FAIL timeout_pre r=%0d got %b exp 1", r, bus.active);
      end
      tick();
      checks++;
      if ({bus.active, bus.siren, bus.muted} !== 3'b000) begin
        errors++;
        $display("FAIL timeout_holdoff r=%0d got %b exp 000", r, {bus.active, bus.siren, bus.muted});
      end
      repeat (63) tick();
      checks++;
      if ({bus.active, bus.muted} !== 2'b00) begin
        errors++;
        $display("FAIL lockout_pre r=%0d got %b exp 00", r, {bus.active, bus.muted});
      end
      tick();
      if (r < 3) begin
        checks++;
        if ({bus.active, bus.siren, bus.muted, bus.resound_cnt} !== {3'b110, 2'(r + 1)}) begin
          errors++;
          $display("FAIL resound r=%0d got %b exp %b", r, {bus.active, bus.siren, bus.muted, bus.resound_cnt}, {3'b110, 2'(r + 1)});
        end
      end else begin
        checks++;
        if ({bus.active, bus.siren, bus.muted, bus.resound_cnt} !== 5'b00111) begin
          errors++;
          $display("FAIL muted_entry got %b exp 00111", {bus.active, bus.siren, bus.muted, bus.resound_cnt});
        end
      end
    end
    repeat (20) tick();
    checks++;
    if (bus.muted !== 1'b1) begin
      errors++;
      $display("FAIL muted_hold got %b exp 1", bus.muted);
    end
    bus.alarm = 1'b0;
    tick();
    checks++;
    if ({bus.active, bus.siren, bus.muted, bus.strobe, bus.resound_cnt} !== 6'b000000) begin
      errors++;
      $display("FAIL muted_exit got %b exp 000000", {bus.active, bus.siren, bus.muted, bus.strobe, bus.resound_cnt});
    end
  endtask

  task automatic test_silence();
    do_reset();
    bus.alarm = 1'b1;
    bus.state = 2'b11;
    tick();
    for (int k = 1; k <= 80; k++) begin
      bus.silence = (k == 10) || (k >= 60 && k <= 76);
      tick();
      case (k)
        9: begin
          checks++;
          if (bus.active !== 1'b1) begin
            errors++;
            $display("FAIL silence_pre got %b exp 1", bus.active);
          end
        end
        10, 75: begin
          checks++;
          if ({bus.active, bus.siren} !== 2'b00) begin
            errors++;
            $display("FAIL silence_ack k=%0d got %b exp 00", k, {bus.active, bus.siren});
          end
        end
        15, 32: begin
          checks++;
          if (bus.strobe !== 1'b0) begin
            errors++;
            $display("FAIL silence_strobe k=%0d got %b exp 0", k, bus.strobe);
          end
        end
        16, 48, 80: begin
          checks++;
          if (bus.strobe !== 1'b1) begin
            errors++;
            $display("FAIL silence_strobe k=%0d got %b exp 1", k, bus.strobe);
          end
        end
        73: begin
          checks++;
          if (bus.active !== 1'b0) begin
            errors++;
            $display("FAIL silence_holdoff got %b exp 0", bus.active);
          end
        end
        74: begin
          checks++;
          if ({bus.active, bus.siren, bus.resound_cnt} !== 4'b1101) begin
            errors++;
            $display("FAIL silence_resound got %b exp 1101", {bus.active, bus.siren, bus.resound_cnt});
          end
        end
        default: ;
      endcase
    end
    bus.silence = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    bus.alarm = 1'b1;
    bus.state = 2'b11;
    tick();
    for (int k = 1; k <= 84; k++) begin
      bus.silence = (k == 5);
      tick();
    end
    checks++;
    if ({bus.active, bus.strobe, bus.resound_cnt} !== 4'b1101) begin
      errors++;
      $display("FAIL drop_pre got %b exp 1101", {bus.active, bus.strobe, bus.resound_cnt});
    end
    bus.alarm   = 1'b0;
    bus.silence = 1'b1;
    tick();
    checks++;
    if ({bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt} !== 6'b000000) begin
      errors++;
      $display("FAIL drop_idle got %b exp 000000", {bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt});
    end
    bus.silence = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.alarm = 1'b1;
    bus.state = 2'b11;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt} !== 6'b000000) begin
      errors++;
      $display("FAIL rst_mid got %b exp 000000", {bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.active, bus.siren, bus.resound_cnt} !== 4'b1100) begin
      errors++;
      $display("FAIL rst_resound got %b exp 1100", {bus.active, bus.siren, bus.resound_cnt});
    end
    repeat (3) tick();
    checks++;
    if (bus.siren !== 1'b1) begin
      errors++;
      $display("FAIL rst_hi_hold got %b exp 1", bus.siren);
    end
    tick();
    checks++;
    if (bus.siren !== 1'b0) begin
      errors++;
      $display("FAIL rst_hi_toggle got %b exp 0", bus.siren);
    end
  endtask

  task automatic test_not_alarm_on();
    logic [1:0] st_vec [2];
    st_vec[0] = 2'b10;
    st_vec[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      bus.alarm = 1'b1;
      bus.state = st_vec[i];
      repeat (5) tick();
      checks++;
      if ({bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt} !== 6'b000000) begin
        errors++;
        $display("FAIL no_trigger st=%b got %b exp 000000", st_vec[i], {bus.active, bus.siren, bus.strobe, bus.muted, bus.resound_cnt});
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.alarm   = 1'b0;
    bus.state   = 2'b00;
    bus.silence = 1'b0;
    test_reset();
    test_tone();
    test_timeout_resound();
    test_silence();
    test_drop();
    test_rst_mid();
    test_not_alarm_on();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_siren_ctrl.md
ALARM_SIREN_CTRL -- requirements
Module: alarm_siren_ctrl

Interface
REQ-001 Parameter TONE_HI_DIV, default 4, half-period in clk cycles of high tone.
REQ-002 Parameter TONE_LO_DIV, default 6, half-period in clk cycles of low tone.
REQ-003 Parameter WARBLE_LEN, default 32, clk cycles per tone before switching HI/LO.
REQ-004 Parameter STROBE_DIV, default 16, half-period in clk cycles of strobe.
REQ-005 Parameter TIMEOUT, default 200, SOUND cycles before auto-silence.
REQ-006 Parameter LOCKOUT, default 64, HOLDOFF cycles before re-sound.
REQ-007 Parameter MAX_RESOUND, default 3, re-sounds permitted before MUTED.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 alarm  in  1  alarm request from alarm FSM.
REQ-011 state  in  2  alarm FSM state (off=00, armed=01, triggered=10, alarm_on=11).
REQ-012 silence  in  1  user acknowledge, sampled each cycle, level or pulse.
REQ-013 siren  out  1  registered audible square wave.
REQ-014 strobe  out  1  registered visual indicator square wave.
REQ-015 active  out  1  high while in SOUND.
REQ-016 muted  out  1  high while in MUTED.
REQ-017 resound_cnt  out  2  re-sounds taken in current alarm episode.

Function
REQ-018 States: IDLE, SOUND, HOLDOFF, MUTED; all outputs registered.
REQ-019 Trigger = alarm=1 and state=11; IDLE -> SOUND on the edge sampling trigger; siren=1 and active=1 from that edge.
REQ-020 SOUND: siren toggles each time tone counter reaches current half-period-1 (counter then wraps to 0); default high tone period 8 cycles.
REQ-021 SOUND: tone select starts HI on entry, flips every WARBLE_LEN cycles; new divisor applies from next tone counter wrap, no truncated half-periods.
REQ-022 SOUND -> HOLDOFF when silence=1 or timeout counter reaches TIMEOUT-1; siren=0 from that edge.
REQ-023 HOLDOFF -> SOUND after LOCKOUT cycles if trigger still true and resound_cnt<MAX_RESOUND; resound_cnt increments on that edge.
REQ-024 HOLDOFF -> MUTED after LOCKOUT cycles if trigger true and resound_cnt=MAX_RESOUND; muted=1.
REQ-025 From SOUND, HOLDOFF, MUTED: trigger false -> IDLE next edge; resound_cnt cleared, all counters cleared.
REQ-026 Priority, same cycle: trigger false > silence > timeout > lockout expiry.
REQ-027 silence in IDLE, HOLDOFF, MUTED ignored; silence held high in SOUND causes immediate HOLDOFF each re-entry.
REQ-028 strobe toggles every STROBE_DIV cycles in SOUND, HOLDOFF, MUTED; 0 in IDLE; strobe counter not cleared between those three states.
REQ-029 Timeout and tone/warble counters clear on every entry to SOUND; lockout counter clears on every entry to HOLDOFF.
REQ-030 Counter widths sized by $clog2 of their parameter; no counter wraps except tone/strobe/warble by design.

Reset
REQ-031 rst=1 at an edge: state IDLE, siren=0, strobe=0, active=0, muted=0, resound_cnt=0, all counters 0, regardless of current state.
REQ-032 First trigger sampled on edge after rst deasserts; trigger during rst ignored.

Structure
REQ-033 Shared package alarm_pkg holds upstream FSM encodings (off, armed, triggered, alarm_on) and siren state enum.
REQ-034 Sub-module siren_tone_gen holds tone counter, warble counter and siren flop, with enable and clear inputs.

Verification
REQ-035 Reset then alarm=1,state=11 at cycle 0 -> siren=1,active=1 at cycle 1; siren toggles every 4 cycles; after 32 cycles half-period becomes 6.
REQ-036 Hold trigger, no silence -> HOLDOFF at cycle 200 (siren=0), SOUND again 64 cycles later, resound_cnt=1; after third re-sound times out -> muted=1 at lockout expiry.
REQ-037 silence pulse at cycle 10 of SOUND -> siren=0, active=0 next edge; strobe continues toggling every 16 cycles.
REQ-038 alarm and silence both drop/rise in same SOUND cycle -> IDLE next edge, strobe=0, resound_cnt=0.
REQ-039 rst asserted mid-SOUND with siren=1 -> all outputs 0 next edge; trigger re-applied -> fresh SOUND with HI tone, resound_cnt=0.
REQ-040 alarm=1 with state=10 -> remains IDLE, all outputs 0.
